// File: rtl/dcache_pass_ctrl_pkg.sv
// rtl/dcache_pass_ctrl_pkg.sv - shared types and constants for the dcache_pass sequencer
package dcache_pass_ctrl_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int DATA_DEPTH  = 8;
    localparam int BE_WIDTH    = DATA_WIDTH / 8;
    localparam int PHYS_WIDTH  = 32;
    localparam int LABEL_WIDTH = PHYS_WIDTH - $clog2(BE_WIDTH);
    localparam int CNT_WIDTH   = $clog2(DATA_DEPTH + 1);

    typedef logic [PHYS_WIDTH-1:0]  phys_t;
    typedef logic [DATA_WIDTH-1:0]  data_t;
    typedef logic [BE_WIDTH-1:0]    be_t;
    typedef logic [LABEL_WIDTH-1:0] label_t;
    typedef logic [CNT_WIDTH-1:0]   cnt_t;

    localparam logic DPASS_LS_STORE = 1'b0;
    localparam logic DPASS_LS_LOAD  = 1'b1;

    // Field order must stay bit-identical to the dcache_pass line_t
    typedef struct packed {
        logic   ls_type;
        be_t    be;
        label_t label;
        data_t  data;
    } dpass_line_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        RESP      = 2'd2
    } dpass_ctrl_state_e;

    function automatic label_t addr_to_label(input phys_t addr);
        return addr[PHYS_WIDTH-1:$clog2(BE_WIDTH)];
    endfunction

endpackage

// File: rtl/dcache_pass_ctrl_if.sv
// rtl/dcache_pass_ctrl_if.sv - MEM-stage request bus and dcache_pass line bus
interface dcache_pass_ctrl_if;
    import dcache_pass_ctrl_pkg::*;

    logic        req;
    logic        req_we;
    logic        req_sync;
    be_t         req_be;
    phys_t       req_addr;
    data_t       req_wdata;
    logic        stall;
    data_t       rdata;
    logic        rdata_vld;
    logic        err;
    dpass_line_t pline;
    logic        push;
    logic        full;
    dpass_line_t rline;
    logic        rline_vld;

    modport master (
        output req, req_we, req_sync, req_be, req_addr, req_wdata, full, rline, rline_vld,
        input  stall, rdata, rdata_vld, err, pline, push
    );

    modport slave (
        input  req, req_we, req_sync, req_be, req_addr, req_wdata, full, rline, rline_vld,
        output stall, rdata, rdata_vld, err, pline, push
    );

endinterface

// File: rtl/dcache_pass_ctrl.sv
// rtl/dcache_pass_ctrl.sv - sequences uncached load/store/sync requests into dcache_pass
module dcache_pass_ctrl
    import dcache_pass_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    dcache_pass_ctrl_if.slave  bus
);

    dpass_ctrl_state_e state_q, state_d;
    cnt_t              outstanding_q, outstanding_d;
    cnt_t              ahead_q, ahead_d;
    label_t            label_q, label_d;
    data_t             rdata_q, rdata_d;
    logic              rdata_vld_q, rdata_vld_d;
    logic              err_q, err_d;

    logic              push_w;
    logic              stall_w;
    dpass_line_t       pline_w;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^bus.req_addr[$clog2(BE_WIDTH)-1:0];

    always_comb begin
        pline_w         = '0;
        pline_w.ls_type = ~bus.req_we;
        pline_w.be      = bus.req_be;
        pline_w.label   = addr_to_label(bus.req_addr);
        pline_w.data    = bus.req_we ? bus.req_wdata : '0;
    end

    // Gated by rst so nothing leaks into dcache_pass while both are held in reset
    assign push_w = bus.req & ~bus.req_sync & ~bus.full & (state_q == IDLE) & ~rst;

    always_comb begin
        stall_w = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.req)          stall_w = 1'b0;
                else if (bus.req_sync) stall_w = (outstanding_q != '0);
                else if (bus.full)     stall_w = 1'b1;
                else                   stall_w = ~bus.req_we;
            end
            WAIT_LOAD: stall_w = 1'b1;
            default:   stall_w = 1'b0;
        endcase
        stall_w = stall_w & ~rst;
    end

    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        ahead_d       = ahead_q;
        label_d       = label_q;
        rdata_d       = rdata_q;
        rdata_vld_d   = 1'b0;
        err_d         = err_q;

        if (bus.rline_vld && outstanding_q == '0) begin
            err_d         = 1'b1;
            outstanding_d = outstanding_q + cnt_t'(push_w);
        end else begin
            outstanding_d = outstanding_q + cnt_t'(push_w) - cnt_t'(bus.rline_vld);
        end

        case (state_q)
            IDLE: begin
                if (push_w && !bus.req_we) begin
                    // Entries still owed ahead of this load, net of one retiring right now
                    ahead_d = (bus.rline_vld && outstanding_q != '0) ? outstanding_q - 1'b1
                                                                     : outstanding_q;
                    label_d = addr_to_label(bus.req_addr);
                    state_d = WAIT_LOAD;
                end
            end
            WAIT_LOAD: begin
                if (bus.rline_vld) begin
                    if (ahead_q != '0) begin
                        ahead_d = ahead_q - 1'b1;
                    end else begin
                        rdata_d     = bus.rline.data;
                        rdata_vld_d = 1'b1;
                        state_d     = RESP;
                        if (bus.rline.ls_type != DPASS_LS_LOAD || bus.rline.label != label_q)
                            err_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            outstanding_q <= '0;
            ahead_q       <= '0;
            label_q       <= '0;
            rdata_q       <= '0;
            rdata_vld_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            ahead_q       <= ahead_d;
            label_q       <= label_d;
            rdata_q       <= rdata_d;
            rdata_vld_q   <= rdata_vld_d;
            err_q         <= err_d;
        end
    end

    assign bus.pline     = pline_w;
    assign bus.push      = push_w;
    assign bus.stall     = stall_w;
    assign bus.rdata     = rdata_q;
    assign bus.rdata_vld = rdata_vld_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_dcache_pass_ctrl.sv
// tb/tb_dcache_pass_ctrl.sv - scoreboard bench for dcache_pass_ctrl
module tb_dcache_pass_ctrl;
    import dcache_pass_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_pass_ctrl_if bus();

    dcache_pass_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests  = 0;
    int failed = 0;

    dpass_line_t exp_pline_q[$];
    data_t       exp_rdata_q[$];
    dpass_line_t pass_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic dpass_line_t mk_line(input logic ls, input be_t be, input phys_t addr,
                                            input data_t d);
        dpass_line_t l;
        l.ls_type = ls;
        l.be      = be;
        l.label   = addr[31:2];
        l.data    = d;
        return l;
    endfunction

    // Monitor: every push and every load response is checked against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.push) begin
                    pass_q.push_back(bus.pline);
                    if (exp_pline_q.size() == 0) chk("unexpected_push", 1'b1, 1'b0);
                    else chk("pline", bus.pline, exp_pline_q.pop_front());
                end
                if (bus.rdata_vld) begin
                    if (exp_rdata_q.size() == 0) chk("unexpected_rdata_vld", 1'b1, 1'b0);
                    else chk("rdata", bus.rdata, exp_rdata_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.rline_vld = 1'b0;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic sync, input be_t be, input phys_t addr,
                         input data_t wd);
        bus.req       = 1'b1;
        bus.req_we    = we;
        bus.req_sync  = sync;
        bus.req_be    = be;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
    endtask

    task automatic store(input phys_t addr, input data_t wd);
        drive(1'b1, 1'b0, 4'hF, addr, wd);
        exp_pline_q.push_back(mk_line(DPASS_LS_STORE, 4'hF, addr, wd));
    endtask

    task automatic load(input phys_t addr, input data_t rd);
        drive(1'b0, 1'b0, 4'hF, addr, '0);
        exp_pline_q.push_back(mk_line(DPASS_LS_LOAD, 4'hF, addr, '0));
        exp_rdata_q.push_back(rd);
    endtask

    task automatic retire(input data_t load_data);
        dpass_line_t l;
        l = '0;
        if (pass_q.size() != 0) l = pass_q.pop_front();
        if (l.ls_type == DPASS_LS_LOAD) l.data = load_data;
        bus.rline     = l;
        bus.rline_vld = 1'b1;
    endtask

    task automatic idle_req();
        bus.req      = 1'b0;
        bus.req_sync = 1'b0;
    endtask

    initial begin
        dpass_line_t l;
        rst = 1'b1;
        idle_req();
        bus.req_we = 1'b0; bus.req_be = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.full = 1'b0; bus.rline = '0; bus.rline_vld = 1'b0;

        // Reset state
        tick(); neg();
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_push", bus.push, 1'b0);
        chk("rst_rdata_vld", bus.rdata_vld, 1'b0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_outstanding", dut.outstanding_q, 4'd0);
        tick(); rst = 1'b0;

        // Single store completes in its push cycle
        tick(); store(32'h10, 32'hDEADBEEF); neg();
        chk("t1_push", bus.push, 1'b1);
        chk("t1_stall", bus.stall, 1'b0);
        chk("t1_label", bus.pline.label, 30'h4);
        tick(); idle_req(); neg();
        chk("t1_outstanding", dut.outstanding_q, 4'd1);
        tick(); retire('0); neg();
        tick(); neg();
        chk("t1_drained", dut.outstanding_q, 4'd0);

        // Three stores then a load; retirements start two cycles after the first push
        tick(); store(32'h100, 32'h1); neg();
        tick(); store(32'h104, 32'h2); neg();
        tick(); store(32'h108, 32'h3); retire('0); neg();
        tick(); load(32'h20, 32'h12345678); retire('0); neg();
        chk("t2_stall_push", bus.stall, 1'b1);
        tick(); retire('0); neg();
        chk("t2_stall_w1", bus.stall, 1'b1);
        tick(); retire(32'h12345678); neg();
        chk("t2_stall_w2", bus.stall, 1'b1);
        tick(); neg();
        chk("t2_stall_resp", bus.stall, 1'b0);
        chk("t2_rdata_vld", bus.rdata_vld, 1'b1);
        tick(); idle_req(); neg();
        chk("t2_rdata_vld_pulse", bus.rdata_vld, 1'b0);
        chk("t2_rdata_hold", bus.rdata, 32'h12345678);
        chk("t2_outstanding", dut.outstanding_q, 4'd0);

        // Store held off by full for five cycles
        tick(); bus.full = 1'b1; drive(1'b1, 1'b0, 4'hF, 32'h200, 32'hAAAA5555);
        for (int i = 0; i < 5; i++) begin
            neg();
            chk("t3_push_full", bus.push, 1'b0);
            chk("t3_stall_full", bus.stall, 1'b1);
            tick();
        end
        bus.full = 1'b0;
        exp_pline_q.push_back(mk_line(DPASS_LS_STORE, 4'hF, 32'h200, 32'hAAAA5555));
        neg();
        chk("t3_push", bus.push, 1'b1);
        chk("t3_stall", bus.stall, 1'b0);
        tick(); idle_req(); neg();
        chk("t3_one_line", pass_q.size(), 1);
        chk("t3_outstanding", dut.outstanding_q, 4'd1);
        tick(); retire('0); neg();

        // Sync with two outstanding
        tick(); store(32'h300, 32'h33); neg();
        tick(); store(32'h304, 32'h44); neg();
        tick(); drive(1'b0, 1'b1, 4'hF, 32'h0, 32'h0); retire('0); neg();
        chk("t4_out2", dut.outstanding_q, 4'd2);
        chk("t4_stall2", bus.stall, 1'b1);
        tick(); retire('0); neg();
        chk("t4_out1", dut.outstanding_q, 4'd1);
        chk("t4_stall1", bus.stall, 1'b1);
        tick(); neg();
        chk("t4_out0", dut.outstanding_q, 4'd0);
        chk("t4_stall0", bus.stall, 1'b0);
        tick(); idle_req();

        // Push and retire in the same cycle
        tick(); store(32'h400, 32'h55); neg();
        tick(); store(32'h404, 32'h66); retire('0); neg();
        tick(); idle_req(); neg();
        chk("t5_outstanding", dut.outstanding_q, 4'd1);
        tick(); retire('0); neg();

        // Load whose returned line carries the wrong label
        tick(); load(32'h40, 32'hCAFEF00D); neg();
        chk("t6_err_before", bus.err, 1'b0);
        tick();
        l = pass_q.pop_front(); l.data = 32'hCAFEF00D; l.label = l.label ^ 30'h1;
        bus.rline = l; bus.rline_vld = 1'b1; neg();
        tick(); neg();
        chk("t6_err", bus.err, 1'b1);
        chk("t6_stall_resp", bus.stall, 1'b0);
        tick(); idle_req(); neg();
        chk("t6_err_sticky", bus.err, 1'b1);

        // Asynchronous reset while waiting for a load
        tick(); load(32'h50, 32'h0); exp_rdata_q.delete(); neg();
        tick(); neg();
        chk("t7_wait", dut.state_q, WAIT_LOAD);
        #2 rst = 1'b1;
        #1;
        chk("t7_state", dut.state_q, IDLE);
        chk("t7_stall", bus.stall, 1'b0);
        chk("t7_rdata_vld", bus.rdata_vld, 1'b0);
        chk("t7_outstanding", dut.outstanding_q, 4'd0);
        chk("t7_err_clr", bus.err, 1'b0);
        pass_q.delete();
        idle_req();
        tick(); rst = 1'b0;

        // Load whose returned line is tagged as a store
        tick(); load(32'h60, 32'h0BADF00D); neg();
        tick();
        l = pass_q.pop_front(); l.data = 32'h0BADF00D; l.ls_type = DPASS_LS_STORE;
        bus.rline = l; bus.rline_vld = 1'b1; neg();
        chk("t8_err_before", bus.err, 1'b0);
        tick(); neg();
        chk("t8_err", bus.err, 1'b1);
        tick(); idle_req(); neg();
        chk("t8_rdata_vld_pulse", bus.rdata_vld, 1'b0);

        // Retirement with nothing outstanding
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        tick(); bus.rline = '0; bus.rline_vld = 1'b1; neg();
        tick(); neg();
        chk("t9_err", bus.err, 1'b1);
        chk("t9_outstanding", dut.outstanding_q, 4'd0);

        tick(); neg();
        chk("exp_pline_drained", exp_pline_q.size(), 0);
        chk("exp_rdata_drained", exp_rdata_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dcache_pass_ctrl.md
Name: dcache_pass_ctrl

Overview:
- Sequences uncached load/store/sync requests from the MEM stage into the dcache_pass FIFO.
- Stores are posted; loads block until their own entry retires. Sync blocks until all outstanding entries retire.
- Tracks the outstanding count, matches returned lines to the pending load and flags protocol violations.
- Sits between the pipeline MEM stage and dcache_pass, and shares that block's clk/rst.

Parameters:
- DATA_WIDTH, 32, data word width; be_t width is DATA_WIDTH/8.
- DATA_DEPTH, 8, dcache_pass FIFO depth; the outstanding counter covers 0..DATA_DEPTH.
- LABEL_WIDTH, $bits(phys_t)-$clog2(DATA_WIDTH/8) (30), word-address label width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req  in  1  request valid; held stable while stall=1.
- req_we  in  1  1=store, 0=load (ignored when req_sync=1).
- req_sync  in  1  drain request; takes priority over req_we.
- req_be  in  DATA_WIDTH/8  byte enables.
- req_addr  in  32 (phys_t)  physical byte address.
- req_wdata  in  DATA_WIDTH  store data.
- stall  out  1  request not yet complete.
- rdata  out  DATA_WIDTH  load data; valid when rdata_vld=1.
- rdata_vld  out  1  load-completion pulse.
- err  out  1  sticky protocol-error flag.
- pline  out  line_t  {ls_type, be, label, data} to dcache_pass.
- push  out  1  push pline into dcache_pass.
- full  in  1  dcache_pass FIFO full.
- rline  in  line_t  retired line from dcache_pass.
- rline_vld  in  1  one line retired this cycle; every pushed entry, load or store, retires exactly once, in order.

Behaviour:
- Reset values: state=IDLE, outstanding=0, ahead=0, rdata=0, rdata_vld=0, err=0, push=0, pline=0.
- pline is combinational:
  - ls_type = ~req_we (0 store, 1 load).
  - be = req_be.
  - label = req_addr[31:2].
  - data = req_wdata for stores, 0 for loads.
- push = req & ~req_sync & ~full & (state==IDLE). push is never asserted while full=1.
- outstanding update per cycle: +1 on push, -1 on rline_vld, unchanged when both occur.
  - rline_vld with outstanding==0 sets err and leaves the counter at 0.
- FSM:
  - IDLE:
    - store: if full, stall=1. Otherwise push and stall=0, so the store completes in the same cycle.
    - load: if full, stall=1. Otherwise push, stall=1, latch ahead = outstanding - rline_vld (retirements still owed ahead of this load) and the expected label, then go to WAIT_LOAD.
    - sync: stall = (outstanding != 0). No push.
    - no req: stall=0.
  - WAIT_LOAD: stall=1.
    - On rline_vld with ahead!=0: ahead -= 1.
    - On rline_vld with ahead==0: this is the load's line. Register rdata = rline data field and go to RESP.
    - If that line has ls_type != 1 or its label differs from the latched label, set err. Data is delivered regardless.
  - RESP: rdata_vld=1 and stall=0, so the held load completes. Go to IDLE. No push this cycle.
- Latency:
  - Store: 0 extra cycles when not full.
  - Load: push cycle, then N cycles until its rline_vld, then 1 RESP cycle.
  - Minimum load latency is 3 cycles with stall high for 2.
- rdata holds its value until the next load response. rdata_vld is a single-cycle pulse.
- err stays set until reset.
- Reset mid-operation clears all state immediately. Because dcache_pass is reset by the same rst, no responses survive.

Decomposition:
- Shared cache package additions:
  - dpass_line_t: packed struct {ls_type, be_t be, label_t label, data_t data}, bit-identical to dcache_pass line_t.
  - Enum dpass_ctrl_state_e: IDLE, WAIT_LOAD, RESP.
  - Constants DPASS_LS_STORE=0 and DPASS_LS_LOAD=1.
- Implemented as a single module; no sub-module is required.

Test Plan:
- Reset, then a store with addr=0x0000_0010, be=0xF, wdata=0xDEADBEEF, full=0 → push=1 in the same cycle; pline={0,F,0x00000004,DEADBEEF}; stall=0; outstanding=1.
- Three stores, then a load with addr=0x20, with rline_vld returning 1 line/cycle starting 2 cycles after the first push → load's rline is the 4th retired; rdata = returned data, e.g. 0x12345678; rdata_vld one cycle; stall high from load push until RESP.
- full=1 held for 5 cycles with a store → push=0 and stall=1 for all 5; on full=0, push=1 and stall=0 in that cycle; exactly one line pushed.
- Sync with 2 outstanding → stall=1 until both rline_vld pulses are seen; stall=0 in the cycle outstanding reads 0.
- Load whose retired line has ls_type=0 or a label mismatch → err=1 and stays 1; rdata_vld still pulses once.
- Push and rline_vld in the same cycle → outstanding unchanged; async rst asserted in WAIT_LOAD → state=IDLE, stall=0, rdata_vld=0, outstanding=0 without waiting for a clock edge.
